// File: rtl/hit_window_scorer_if.sv
// Sensor, control and score-display bundle for the windowed hit scorer.
// The master side drives arming, clear and sensor levels. The slave side drives the score outputs.
interface hit_window_scorer_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 8
);
    logic              enA;
    logic              clear;
    logic [NUM_CH-1:0] hit_in;
    logic [CNT_W-1:0]  score;
    logic [3:0]        score_ones;
    logic [3:0]        score_tens;
    logic              window_pulse;
    logic              score_pulse;
    logic              saturated;

    modport master (
        output enA, clear, hit_in,
        input  score, score_ones, score_tens, window_pulse, score_pulse, saturated
    );

    modport slave (
        input  enA, clear, hit_in,
        output score, score_ones, score_tens, window_pulse, score_pulse, saturated
    );
endinterface

// File: rtl/hit_window_scorer.sv
// Groups synchronised sensor rising edges into fixed-length windows.
// Each closed window adds to a saturating score that is shown in binary and as BCD digits.
module hit_window_scorer #(
    parameter int NUM_CH        = 3,
    parameter int WINDOW_CYCLES = 100000000,
    parameter int CNT_W         = 8,
    parameter int MAX_SCORE     = 99,
    parameter int MODE          = 0
) (
    input  logic             clock,
    input  logic             reset,
    hit_window_scorer_if.slave bus
);
    localparam int WIN_W = $clog2(WINDOW_CYCLES);
    localparam int SUM_W = CNT_W + 4;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [SUM_W-1:0] MAX_EXT  = SUM_W'(MAX_SCORE);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    function automatic logic [3:0] popcount(input logic [NUM_CH-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] t;
        logic [CNT_W-1:0] o;
        t = v / CNT_W'(10);
        o = v - t * CNT_W'(10);
        return {t[3:0], o[3:0]};
    endfunction

    logic [NUM_CH-1:0] sync1_r, sync2_r, sync3_r;
    logic [1:0]        state_r;
    logic [WIN_W-1:0]  win_cnt_r;
    logic [NUM_CH-1:0] flags_r;
    logic [CNT_W-1:0]  score_r;
    logic [3:0]        ones_r, tens_r;
    logic              window_pulse_r, score_pulse_r, saturated_r;

    logic [NUM_CH-1:0] edge_s;
    logic [3:0]        inc_s;
    logic [SUM_W-1:0]  sum_s;
    logic [CNT_W-1:0]  next_score_s;
    logic              raised_s;
    logic [7:0]        bcd_s;

    // Edge detection and the saturating increment for the closing window.
    always_comb begin
        edge_s = sync2_r & ~sync3_r;
        if (MODE == 0) begin
            inc_s = {3'd0, |flags_r};
        end else begin
            inc_s = popcount(flags_r);
        end
        // The wide sum cannot wrap, so the clamp sees the true total.
        sum_s = {4'd0, score_r} + {{CNT_W{1'b0}}, inc_s};
        if (sum_s > MAX_EXT) begin
            next_score_s = CNT_W'(MAX_SCORE);
        end else begin
            next_score_s = sum_s[CNT_W-1:0];
        end
        raised_s = (next_score_s > score_r);
        bcd_s    = to_bcd(score_r);
    end

    // Two-flop synchroniser plus a third stage for rising-edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
            sync3_r <= '0;
        end else begin
            sync1_r <= bus.hit_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
        end
    end

    // Window sequencer: collects sticky flags while armed and closes the window in COMMIT.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            win_cnt_r      <= '0;
            flags_r        <= '0;
            window_pulse_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    win_cnt_r      <= '0;
                    flags_r        <= '0;
                    window_pulse_r <= 1'b0;
                    state_r        <= bus.enA ? ST_ARMED : ST_IDLE;
                end
                ST_ARMED: begin
                    if (!bus.enA) begin
                        state_r        <= ST_IDLE;
                        win_cnt_r      <= '0;
                        flags_r        <= '0;
                        window_pulse_r <= 1'b0;
                    end else if (win_cnt_r == WIN_LAST) begin
                        state_r        <= ST_COMMIT;
                        win_cnt_r      <= '0;
                        flags_r        <= flags_r | edge_s;
                        window_pulse_r <= 1'b1;
                    end else begin
                        state_r        <= ST_ARMED;
                        win_cnt_r      <= win_cnt_r + WIN_W'(1);
                        flags_r        <= flags_r | edge_s;
                        window_pulse_r <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    // Edges seen during COMMIT seed the next window.
                    flags_r        <= edge_s;
                    win_cnt_r      <= '0;
                    window_pulse_r <= 1'b0;
                    state_r        <= bus.enA ? ST_ARMED : ST_IDLE;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    win_cnt_r      <= '0;
                    flags_r        <= '0;
                    window_pulse_r <= 1'b0;
                end
            endcase
        end
    end

    // Score register: clear takes priority over a simultaneous commit.
    always_ff @(posedge clock) begin
        if (reset) begin
            score_r       <= '0;
            score_pulse_r <= 1'b0;
        end else if (bus.clear) begin
            score_r       <= '0;
            score_pulse_r <= 1'b0;
        end else if (state_r == ST_COMMIT) begin
            score_r       <= next_score_s;
            score_pulse_r <= raised_s;
        end else begin
            score_pulse_r <= 1'b0;
        end
    end

    // Display digits and the saturation flag trail the score by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ones_r      <= 4'd0;
            tens_r      <= 4'd0;
            saturated_r <= 1'b0;
        end else begin
            ones_r      <= bcd_s[3:0];
            tens_r      <= bcd_s[7:4];
            saturated_r <= (score_r == CNT_W'(MAX_SCORE));
        end
    end

    assign bus.score        = score_r;
    assign bus.score_ones   = ones_r;
    assign bus.score_tens   = tens_r;
    assign bus.window_pulse = window_pulse_r;
    assign bus.score_pulse  = score_pulse_r;
    assign bus.saturated    = saturated_r;
endmodule
